// File: rtl/debounce_array.sv
// debounce_array: N_CH-channel push-button conditioner. Each pin is synchronised,
// debounced by a stability counter, and presented as a level plus rise/fall pulses;
// an optional per-channel auto-repeat generator pulses while a button is held.
// Ports: clk, reset (sync, active-high), btn_in[N_CH] raw pins,
//        btn_level/btn_rise/btn_fall/btn_repeat[N_CH] registered outputs.
module debounce_array #(
  parameter int N_CH            = 4,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_EN       = 0,
  parameter int RPT_W           = 24,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_repeat
);

  typedef enum logic [1:0] {RELEASED, HELD, REPEATING} rpt_state_t;

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [N_CH-1:0]  PIN_INV     = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  // Two-flop synchroniser; polarity is normalised before the first flop so
  // everything downstream sees 1 = pressed.
  logic [N_CH-1:0] s1, s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in ^ PIN_INV;
      s2 <= s1;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             level, rise, fall, rpt;
    logic             accept, rise_evt, fall_evt;

    // The new level is accepted on the cycle the counter would reach
    // DEBOUNCE_CYCLES, so the counter itself never exceeds DB_LAST.
    assign accept   = (s2[ch] != level) && (cnt == DB_LAST);
    assign rise_evt = accept &&  s2[ch];
    assign fall_evt = accept && !s2[ch];

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        level <= 1'b0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        rise <= rise_evt;
        fall <= fall_evt;
        if ((s2[ch] == level) || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        if (accept) begin
          level <= s2[ch];
        end
      end
    end

    if (REPEAT_EN != 0) begin : g_rpt
      rpt_state_t       state;
      logic [RPT_W-1:0] rcnt;

      // Repeat timing is keyed off the same edge that registers btn_rise, so
      // the first pulse lands exactly REPEAT_DELAY cycles after the rise cycle.
      // A release always wins over a coincident terminal count.
      always_ff @(posedge clk) begin
        if (reset) begin
          state <= RELEASED;
          rcnt  <= '0;
          rpt   <= 1'b0;
        end else begin
          rpt <= 1'b0;
          case (state)
            RELEASED: begin
              rcnt <= '0;
              if (rise_evt) state <= HELD;
            end
            HELD: begin
              if (fall_evt) begin
                state <= RELEASED;
                rcnt  <= '0;
              end else if (rcnt == DELAY_LAST) begin
                state <= REPEATING;
                rcnt  <= '0;
                rpt   <= 1'b1;
              end else begin
                rcnt <= rcnt + RPT_W'(1);
              end
            end
            REPEATING: begin
              if (fall_evt) begin
                state <= RELEASED;
                rcnt  <= '0;
              end else if (rcnt == PERIOD_LAST) begin
                rcnt <= '0;
                rpt  <= 1'b1;
              end else begin
                rcnt <= rcnt + RPT_W'(1);
              end
            end
            default: begin
              state <= RELEASED;
              rcnt  <= '0;
            end
          endcase
        end
      end
    end else begin : g_no_rpt
      assign rpt = 1'b0;
    end

    assign btn_level[ch]  = level;
    assign btn_rise[ch]   = rise;
    assign btn_fall[ch]   = fall;
    assign btn_repeat[ch] = rpt;
  end

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array: a 4-channel active-high instance with
// auto-repeat and a 1-channel active-low instance without, sharing clk/reset.
// Expectations are queued with each stimulus step and checked one cycle-step later.
module tb_debounce_array;

  logic       clk;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] btn_level, btn_rise, btn_fall, btn_repeat;
  logic [0:0] al_in;
  logic [0:0] al_level, al_rise, al_fall, al_repeat;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] rpt;
    logic [3:0] al;   // {level, rise, fall, repeat} of the active-low instance
  } exp_t;

  exp_t sb[$];

  debounce_array #(
    .N_CH(4), .CNT_W(8), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0),
    .REPEAT_EN(1), .RPT_W(8), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(btn_level), .btn_rise(btn_rise),
    .btn_fall(btn_fall), .btn_repeat(btn_repeat)
  );

  debounce_array #(
    .N_CH(1), .CNT_W(8), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
    .REPEAT_EN(0), .RPT_W(8), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut_al (
    .clk(clk), .reset(reset), .btn_in(al_in),
    .btn_level(al_level), .btn_rise(al_rise),
    .btn_fall(al_fall), .btn_repeat(al_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the expectation, advance n edges, sample 1 time unit after the edge.
  task automatic step(input int n, input string tag, input logic [3:0] lvl,
                      input logic [3:0] rise, input logic [3:0] fall,
                      input logic [3:0] rpt, input logic [3:0] al);
    exp_t e;
    logic [19:0] obs, expv;
    e.tag = tag; e.lvl = lvl; e.rise = rise; e.fall = fall; e.rpt = rpt; e.al = al;
    sb.push_back(e);
    repeat (n) @(posedge clk);
    #1;
    e = sb.pop_front();
    obs  = {btn_level, btn_rise, btn_fall, btn_repeat,
            al_level, al_rise, al_fall, al_repeat};
    expv = {e.lvl, e.rise, e.fall, e.rpt, e.al};
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed lvl=%h rise=%h fall=%h rpt=%h al=%b, expected lvl=%h rise=%h fall=%h rpt=%h al=%b",
             e.tag, obs[19:16], obs[15:12], obs[11:8], obs[7:4], obs[3:0],
             e.lvl, e.rise, e.fall, e.rpt, e.al);
    end
  endtask

  initial begin
    logic [9:0] bounce;
    bit         r;

    // Reset held 3 cycles with all buttons pressed.
    reset = 1'b1;
    btn_in = 4'hF;
    al_in = 1'b1;
    step(1, "reset_c1", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    step(2, "reset_c3", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    reset = 1'b0;
    step(5, "post_reset_e5", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    step(1, "post_reset_e6", 4'hF, 4'hF, 4'h0, 4'h0, 4'b0000);
    step(1, "post_reset_e7", 4'hF, 4'h0, 4'h0, 4'h0, 4'b0000);

    // Reset mid-operation clears levels and repeat state.
    reset = 1'b1;
    btn_in = 4'h0;
    step(2, "mid_reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    reset = 1'b0;
    step(1, "mid_reset_rel", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);

    // Clean press and release on ch0.
    btn_in = 4'h1;
    step(5, "ch0_press_e5", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    step(1, "ch0_press_e6", 4'h1, 4'h1, 4'h0, 4'h0, 4'b0000);
    btn_in = 4'h0;
    step(5, "ch0_rel_e5", 4'h1, 4'h0, 4'h0, 4'h0, 4'b0000);
    step(1, "ch0_rel_e6", 4'h0, 4'h0, 4'h1, 4'h0, 4'b0000);
    step(2, "ch0_idle", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);

    // Bounce on ch1: high runs of 3 never reach the 4-sample threshold.
    bounce = 10'b0011100111;
    for (int i = 0; i < 10; i++) begin
      btn_in = {2'b00, bounce[i], 1'b0};
      step(1, $sformatf("ch1_bounce_%0d", i), 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    end
    btn_in = 4'h2;
    step(5, "ch1_hold_e5", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    step(1, "ch1_hold_e6", 4'h2, 4'h2, 4'h0, 4'h0, 4'b0000);
    btn_in = 4'h0;
    step(1, "ch1_single_rise", 4'h2, 4'h0, 4'h0, 4'h0, 4'b0000);
    step(5, "ch1_rel_e6", 4'h0, 4'h0, 4'h2, 4'h0, 4'b0000);
    step(2, "ch1_idle", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);

    // Auto-repeat on ch2: rise, then repeats at +8, +11, +14, +17, +20, +23;
    // released at +20 so the fall lands at +26 on a repeat terminal count.
    btn_in = 4'h4;
    step(5, "ch2_press_e5", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    step(1, "ch2_rise", 4'h4, 4'h4, 4'h0, 4'h0, 4'b0000);
    for (int k = 1; k <= 30; k++) begin
      r = (k < 26) && ((k == 8) || ((k > 8) && ((k - 8) % 3 == 0)));
      step(1, $sformatf("ch2_rpt_%0d", k), (k < 26) ? 4'h4 : 4'h0, 4'h0,
           (k == 26) ? 4'h4 : 4'h0, r ? 4'h4 : 4'h0, 4'b0000);
      if (k == 20) btn_in = 4'h0;
    end

    // ch3: fall coincides with the first-repeat terminal count in HELD.
    btn_in = 4'h8;
    step(5, "ch3_press_e5", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    step(1, "ch3_rise", 4'h8, 4'h8, 4'h0, 4'h0, 4'b0000);
    step(2, "ch3_held_2", 4'h8, 4'h0, 4'h0, 4'h0, 4'b0000);
    btn_in = 4'h0;
    step(5, "ch3_held_7", 4'h8, 4'h0, 4'h0, 4'h0, 4'b0000);
    step(1, "ch3_fall_wins", 4'h0, 4'h0, 4'h8, 4'h0, 4'b0000);
    step(1, "ch3_idle", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);

    // Active-low instance: pin low = pressed.
    al_in = 1'b0;
    step(5, "al_press_e5", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    step(1, "al_press_e6", 4'h0, 4'h0, 4'h0, 4'h0, 4'b1100);
    al_in = 1'b1;
    step(5, "al_rel_e5", 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000);
    step(1, "al_rel_e6", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010);
    step(1, "al_idle", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
